md_sched: RTL and testbench

- Sequencer for the EX-stage multiply/divide resource.
- Accepts one operation per start pulse from the EX controller, latches the operands, and holds the unit busy for a fixed, op-dependent number of cycles.
- Commits the result to the HI/LO registers and serves mfhi/mflo reads.
- Generates the stall request the hazard controller uses to freeze IF/ID while an MD-class instruction in ID would collide with the running operation.

---
 rtl/md_sched_if.sv | 25 ++
 rtl/md_sched.sv | 142 ++++++++++++++
 tb/tb_md_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// Bus between the EX/hazard controllers and the multiply/divide sequencer.
// The master modport is the controller side, and the slave modport is the sequencer.
interface md_sched_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_sel;
   logic        id_md_use;
   logic [31:0] rd_data;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, rd_sel, id_md_use,
      input  rd_data, busy, md_stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, rd_sel, id_md_use,
      output rd_data, busy, md_stall, hi, lo
   );
endinterface

// File: rtl/md_sched.sv
// Sequencer for the EX-stage multiply/divide unit. It latches the operands, stays busy for an
// op-dependent number of cycles, commits the result to HI/LO and raises the IF/ID stall request.
module md_sched #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_sched_if.slave md
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] MUL_CNT  = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q, hi_q, lo_q;
   logic        accept, commit, is_md_op, is_div_req, busy;

   function automatic logic [31:0] mag(input logic signed [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? 32'(-v) : 32'(v);
   endfunction

   function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign is_md_op   = (md.op >= OP_MULT) && (md.op <= OP_DIVU);
   assign is_div_req = (md.op == OP_DIV) || (md.op == OP_DIVU);
   assign busy       = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (md.start && is_md_op) begin
               accept  = 1'b1;
               state_d = RUN;
               cnt_d   = is_div_req ? DIV_CNT : MUL_CNT;
            end
         end
         RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Result datapath: operates only on the latched operands and becomes visible at commit.
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               div_signed, a_neg, b_neg, div_by_zero;
   logic [31:0]        a_mag, b_mag, divisor, q_mag, r_mag;
   logic [31:0]        res_hi, res_lo;

   assign prod_s      = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u      = {32'd0, a_q} * {32'd0, b_q};
   assign div_signed  = (op_q == OP_DIV);
   assign a_neg       = div_signed & a_q[31];
   assign b_neg       = div_signed & b_q[31];
   assign a_mag       = mag(a_q, div_signed);
   assign b_mag       = mag(b_q, div_signed);
   // The zero divisor is replaced so that the divider never sees it; the result is discarded anyway.
   assign divisor     = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_mag       = a_mag / divisor;
   assign r_mag       = a_mag % divisor;
   assign div_by_zero = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0);

   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      case (op_q)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            res_lo = apply_sign(q_mag, a_neg ^ b_neg);
            res_hi = apply_sign(r_mag, a_neg);
         end
         OP_DIVU: begin
            res_lo = q_mag;
            res_hi = r_mag;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q <= 4'd0;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         if (accept) begin
            op_q <= md.op;
            a_q  <= md.a;
            b_q  <= md.b;
         end
         if (commit) begin
            if (!div_by_zero) begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
         end else if ((state_q == IDLE) && md.start) begin
            if (md.op == OP_MTHI) hi_q <= md.a;
            if (md.op == OP_MTLO) lo_q <= md.a;
         end
      end
   end

   assign md.busy     = busy;
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;
   assign md.rd_data  = md.rd_sel ? hi_q : lo_q;
   assign md.md_stall = md.id_md_use & (busy | (md.start & is_md_op));
endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched. It models the expected HI/LO results and the busy length
// of each operation, and compares them when the unit drops busy.
module tb_md_sched;
   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   md_sched_if md_bus();

   md_sched #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_miss = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ohi, input logic [31:0] olo);
      exp_t e;
      longint sa, sbv, q, r;
      logic [63:0] p;
      e.hi = ohi;
      e.lo = olo;
      e.cyc = (op >= 4'd3) ? DIV_N : MUL_N;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         4'd1: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
         4'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         4'd3: if (b != 0) begin
            q = sa / sbv; r = sa % sbv;
            e.lo = q[31:0]; e.hi = r[31:0];
         end
         4'd4: if (b != 0) begin e.lo = a / b; e.hi = a % b; end
         default: ;
      endcase
      return e;
   endfunction

   // inj: 0 none, 1 mthi issued mid-run, 2 mult issued on the commit edge
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic id_use, input int inj);
      exp_t e;
      int cyc;
      @(negedge clk);
      md_bus.start = 1'b1; md_bus.op = op; md_bus.a = a; md_bus.b = b; md_bus.id_md_use = id_use;
      #1;
      check("stall_start", md_bus.md_stall, id_use);
      check("idle_before", md_bus.busy, 1'b0);
      sb.push_back(model(op, a, b, m_hi, m_lo));
      @(negedge clk);
      md_bus.start = 1'b0;
      cyc = 0;
      while (md_bus.busy && cyc < 40) begin
         check("stall_run", md_bus.md_stall, id_use);
         check("hold_hilo", {md_bus.hi, md_bus.lo}, {m_hi, m_lo});
         cyc++;
         md_bus.start = 1'b0;
         if (inj == 1 && cyc == 2) begin
            md_bus.start = 1'b1; md_bus.op = 4'd5; md_bus.a = 32'hDEAD_BEEF;
         end
         if (inj == 2 && cyc == sb[0].cyc) begin
            md_bus.start = 1'b1; md_bus.op = 4'd1; md_bus.a = 32'd3; md_bus.b = 32'd3;
         end
         @(negedge clk);
      end
      md_bus.start = 1'b0;
      #1;
      e = sb.pop_front();
      check("busy_cycles", 64'(cyc), 64'(e.cyc));
      check("stall_after", md_bus.md_stall, 1'b0);
      check("res_hi", md_bus.hi, e.hi);
      check("res_lo", md_bus.lo, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
      if (inj == 2) begin
         @(negedge clk);
         check("commit_edge_start", md_bus.busy, 1'b0);
      end
      md_bus.id_md_use = 1'b0;
   endtask

   task automatic mt_pair(input logic [31:0] h, input logic [31:0] l);
      @(negedge clk);
      md_bus.start = 1'b1; md_bus.op = 4'd5; md_bus.a = h;
      @(negedge clk);
      check("mt_busy0", md_bus.busy, 1'b0);
      md_bus.op = 4'd6; md_bus.a = l;
      @(negedge clk);
      md_bus.start = 1'b0; md_bus.op = 4'd0;
      check("mt_busy1", md_bus.busy, 1'b0);
      check("mthi", md_bus.hi, h);
      check("mtlo", md_bus.lo, l);
      m_hi = h;
      m_lo = l;
   endtask

   initial begin
      md_bus.start = 1'b0; md_bus.op = 4'd0; md_bus.a = 32'd0; md_bus.b = 32'd0;
      md_bus.rd_sel = 1'b0; md_bus.id_md_use = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", md_bus.busy, 1'b0);
      check("rst_hi", md_bus.hi, 32'd0);
      check("rst_lo", md_bus.lo, 32'd0);
      check("rst_stall", md_bus.md_stall, 1'b0);
      reset = 1'b1;

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      mt_pair(32'h11, 32'h22);
      run_op(4'd4, 32'd7, 32'd0, 1'b0, 0);
      mt_pair(32'h1234, 32'h5678);
      md_bus.rd_sel = 1'b1; #1;
      check("rd_hi", md_bus.rd_data, 32'h1234);
      md_bus.rd_sel = 1'b0; #1;
      check("rd_lo", md_bus.rd_data, 32'h5678);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1);
      run_op(4'd4, 32'd100, 32'd7, 1'b0, 2);
      run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
      for (int i = 0; i < 6; i++)
         run_op(4'(1 + (i % 4)), $urandom, $urandom, 1'(i % 2), 0);

      // Reset pulled in the middle of a multiply
      mt_pair(32'hAA, 32'hBB);
      @(negedge clk);
      md_bus.start = 1'b1; md_bus.op = 4'd1; md_bus.a = 32'd5; md_bus.b = 32'd7;
      @(negedge clk);
      md_bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_busy", md_bus.busy, 1'b1);
      reset = 1'b0;
      #1;
      check("arst_busy", md_bus.busy, 1'b0);
      check("arst_hi", md_bus.hi, 32'd0);
      check("arst_lo", md_bus.lo, 32'd0);
      check("arst_rd", md_bus.rd_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      check("post_rst_busy", md_bus.busy, 1'b0);
      run_op(4'd2, 32'd6, 32'd9, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
